casu_update_engine: RTL
=======================

# casu_update_engine

Hardware copy engine that moves an authenticated update image from the staging buffer into the executable region (ER), one 16-bit word at a time, over a request/acknowledge memory port. It is the writing side of the CASU update path. The monitor forbids every ER write except those issued under trusted code, and this engine is the only sanctioned ER writer. Trusted code in SMEM programs it and starts it. While it writes, it drives `er_wr_active` so the monitor can attribute the writes.

## Interface
Parameters:
- `SMEM_BASE`, 16'hA000, trusted code base
- `SMEM_SIZE`, 16'h4000, trusted code size
- `STAGE_BASE`, 16'h8000, staging buffer base
- `STAGE_SIZE`, 16'h1000, staging buffer size in bytes
- `MAX_WORDS`, 16'h0800, largest allowed transfer in words

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `pc` in 16: current CPU program counter.
- `start` in 1: one-cycle command strobe.
- `src_base` in 16, `dst_base` in 16: byte addresses; must be even.
- `len_words` in 16: transfer length in words.
- `ER_min` in 16, `ER_max` in 16: ER bounds, inclusive.
- `kill` in 1: violation reset from the monitor.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 16, `mem_wdata` out 16: memory request.
- `mem_ack` in 1, `mem_rdata` in 16: memory response.
- `busy` out 1, `done` out 1 (pulse), `err` out 1 (sticky), `er_wr_active` out 1.

## Operation
- States: IDLE, RD, WR, DONE, ERR.
- IDLE, `start`=1: command is valid only if all of the following hold:
  - `pc` lies in [SMEM_BASE, SMEM_BASE+SMEM_SIZE-2].
  - `len_words` is in 1..MAX_WORDS.
  - `src_base` and `dst_base` are both even.
  - [src_base, src_base+2*len-1] lies inside the staging buffer.
  - [dst_base, dst_base+2*len-1] lies inside [ER_min, ER_max].
  - All end addresses are computed in 17 bits; a carry out of bit 15 makes the command invalid.
- Valid command: latch the operands, set word index i=0, go to RD. Invalid command: go to ERR.
- RD: `mem_req`=1, `mem_we`=0, `mem_addr`=src+2i. On `mem_ack`, capture `mem_rdata` and go to WR.
- WR: `mem_req`=1, `mem_we`=1, `mem_addr`=dst+2i, `mem_wdata`=captured word, `er_wr_active`=1. On `mem_ack`, increment i. If i+1==len, go to DONE; otherwise go to RD.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- ERR: `err`=1 for one cycle, then IDLE. `err` stays high until the next accepted `start`.
- `kill`=1 in any state except IDLE:
  - Next state is ERR and `err` is set.
  - `mem_req` drops the same cycle (combinational gate); a pending beat is abandoned.
  - No further ER write may be issued.
- `start` while `busy` is ignored.
- `start` and `kill` in the same IDLE cycle: `kill` wins. The command is dropped and `err` is not set.
- `reset`: state IDLE. All outputs 0, including `err`. Latched operands cleared.

## Timing
- Reset values: `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `err`=0, `er_wr_active`=0.
- `start` sampled on edge t:
  - Valid command: `busy`=1 and `mem_req`=1 from cycle t+1.
  - Invalid command: `err`=1 from t+1.
- Handshake:
  - `mem_addr`, `mem_we` and `mem_wdata` are stable while `mem_req`=1 and `mem_ack`=0.
  - A beat completes on a cycle with `mem_req`&&`mem_ack`.
  - `mem_rdata` is valid in the ack cycle.
  - Zero-wait memory: each word costs 2 cycles.
- Latency with zero-wait memory:
  - `done` asserts at t+2N+1 for N words.
  - `busy` falls in the cycle after `done`.
- Memory outputs are registered except the `kill` gating on `mem_req`.
- `er_wr_active` equals the WR state gated by `!kill`.

## Structure
- Shared package `casu_pkg` holds:
  - the state enum;
  - SMEM, staging and EP region constants;
  - the word step (2).
- The monitor imports the same constants.
- One sub-module, `casu_range_check`: combinational, takes base, length and a window and outputs `in_range`. It uses 17-bit end arithmetic with overflow detection. It is instantiated twice, once for the source window and once for the ER window.

## Test plan
- Nominal copy:
  - Setup: pc=16'hA010, src=16'h8000, dst=ER_min=16'hE000, ER_max=16'hE0FF, len=4, zero-wait ack.
  - Expect 8 beats in the order R8000, WE000, R8002, WE002, and so on.
  - Expect `done` exactly at t+9 and write data equal to the words read.
- Untrusted start: pc=16'h4000 with an otherwise valid command → no `mem_req` ever asserts; `err`=1 at t+1.
- Bounds:
  - len=0 → ERR.
  - dst=16'hE0FE with len=2 (end 16'hE101 > ER_max) → ERR.
  - src=16'hFFFE with len=2 (17-bit wrap) → ERR.
  - In each case, zero memory beats are issued.
- Wait states: hold `mem_ack` low for 3 cycles on each beat → addresses and data stay stable; `done` asserts at t+1+2N*4.
- `kill` in the middle of the 2nd WR beat → `mem_req` is 0 in that same cycle; ERR follows; no further write; `err` stays high until the next valid `start`.
- `reset` during RD, and `start` pulsed while busy:
  - Reset returns every output to 0 in the next cycle.
  - The extra `start` does not alter the latched operands or the beat sequence.

Source files
------------

// File: rtl/casu_pkg.sv
// Shared constants and types for the CASU update path (engine and monitor).
package casu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWr,
    StDone,
    StErr
  } casu_state_e;

  localparam logic [15:0] SmemBase  = 16'hA000;
  localparam logic [15:0] SmemSize  = 16'h4000;
  localparam logic [15:0] StageBase = 16'h8000;
  localparam logic [15:0] StageSize = 16'h1000;
  localparam logic [15:0] MaxWords  = 16'h0800;
  localparam logic [15:0] ErMinDef  = 16'hE000;
  localparam logic [15:0] ErMaxDef  = 16'hFFDF;
  localparam logic [15:0] WordStep  = 16'd2;

  function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [15:0] idx);
    return base + idx * WordStep;
  endfunction

endpackage

// File: rtl/casu_update_engine_if.sv
// Request/acknowledge memory port between the update engine and memory.
interface casu_update_engine_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/casu_range_check.sv
// Checks that [base, base+2*len_words-1] lies within [win_lo, win_hi] without address wrap.
module casu_range_check (
  input  logic [15:0] base,
  input  logic [15:0] len_words,
  input  logic [15:0] win_lo,
  input  logic [15:0] win_hi,
  output logic        in_range
);

  logic [17:0] end_addr;

  // Extra high bits catch any carry out of the 16-bit address space.
  always_comb begin
    end_addr = {2'b00, base} + {1'b0, len_words, 1'b0} - 18'd1;
    in_range = (len_words != 16'd0) && (base >= win_lo) &&
               (end_addr[17:16] == 2'b00) && (end_addr[15:0] <= win_hi);
  end

endmodule

// File: rtl/casu_update_engine.sv
// Trusted staging-to-ER copy engine; the only sanctioned writer of the executable region.
module casu_update_engine
  import casu_pkg::*;
#(
  parameter logic [15:0] SMEM_BASE  = SmemBase,
  parameter logic [15:0] SMEM_SIZE  = SmemSize,
  parameter logic [15:0] STAGE_BASE = StageBase,
  parameter logic [15:0] STAGE_SIZE = StageSize,
  parameter logic [15:0] MAX_WORDS  = MaxWords
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [15:0]                 pc,
  input  logic                        start,
  input  logic [15:0]                 src_base,
  input  logic [15:0]                 dst_base,
  input  logic [15:0]                 len_words,
  input  logic [15:0]                 ER_min,
  input  logic [15:0]                 ER_max,
  input  logic                        kill,
  casu_update_engine_if.master        mem,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic                        er_wr_active
);

  localparam logic [15:0] StageHi = STAGE_BASE + STAGE_SIZE - 16'd1;
  localparam logic [16:0] PcHi    = {1'b0, SMEM_BASE} + {1'b0, SMEM_SIZE} - 17'd2;

  casu_state_e state_q, state_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic        err_q, err_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;

  logic src_ok, dst_ok, pc_ok, len_ok, cmd_valid, beat;

  casu_range_check u_src_check (
    .base      (src_base),
    .len_words (len_words),
    .win_lo    (STAGE_BASE),
    .win_hi    (StageHi),
    .in_range  (src_ok)
  );

  casu_range_check u_dst_check (
    .base      (dst_base),
    .len_words (len_words),
    .win_lo    (ER_min),
    .win_hi    (ER_max),
    .in_range  (dst_ok)
  );

  always_comb begin
    pc_ok     = (pc >= SMEM_BASE) && ({1'b0, pc} <= PcHi);
    len_ok    = (len_words != 16'd0) && (len_words <= MAX_WORDS);
    cmd_valid = pc_ok && len_ok && !src_base[0] && !dst_base[0] && src_ok && dst_ok;
    beat      = mem_req_q && mem.mem_ack;
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    idx_d       = idx_q;
    err_d       = err_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      StIdle: begin
        // A simultaneous kill drops the command without flagging an error.
        if (start && !kill) begin
          if (cmd_valid) begin
            src_d   = src_base;
            dst_d   = dst_base;
            len_d   = len_words;
            idx_d   = 16'd0;
            err_d   = 1'b0;
            state_d = StRd;
          end else begin
            err_d   = 1'b1;
            state_d = StErr;
          end
        end
      end
      StRd: begin
        if (beat) begin
          mem_wdata_d = mem.mem_rdata;
          state_d     = StWr;
        end
      end
      StWr: begin
        if (beat) begin
          idx_d   = idx_q + 16'd1;
          state_d = (idx_q + 16'd1 == len_q) ? StDone : StRd;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (kill && state_q != StIdle) begin
      state_d = StErr;
      err_d   = 1'b1;
    end

    // Request outputs are registered from the next state so they line up with it.
    mem_req_d  = (state_d == StRd) || (state_d == StWr);
    mem_we_d   = (state_d == StWr);
    mem_addr_d = mem_addr_q;
    if (state_d == StRd) begin
      mem_addr_d = word_addr(src_d, idx_d);
    end else if (state_d == StWr) begin
      mem_addr_d = word_addr(dst_d, idx_d);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      src_q       <= 16'd0;
      dst_q       <= 16'd0;
      len_q       <= 16'd0;
      idx_q       <= 16'd0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'd0;
      mem_wdata_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Kill must stop an in-flight request within the same cycle.
  assign mem.mem_req   = mem_req_q && !kill;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

  assign busy         = (state_q == StRd) || (state_q == StWr) || (state_q == StDone);
  assign done         = (state_q == StDone);
  assign err          = err_q;
  assign er_wr_active = (state_q == StWr) && !kill;

endmodule
